// File: rtl/pipe_hazard_pkg.sv
// pipe_hazard_pkg: scoreboard entry type, constants and the register-match helper shared by the hazard unit.
package pipe_hazard_pkg;
  typedef struct packed {
    logic       val;
    logic       wen;
    logic [4:0] waddr;
    logic       is_load;
    logic       is_branch;
  } hz_entry_t;
  localparam int BYP_RF = 0;
  localparam logic [4:0] REG_X0 = 5'd0;
  function automatic logic hz_match(input hz_entry_t e, input logic rd_en, input logic [4:0] rs);
    return rd_en & e.val & e.wen & (e.waddr == rs) & (rs != REG_X0);
  endfunction
endpackage

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: one scoreboard entry register with hold enable and synchronous active-low clear.
module hazard_stage_reg
  import pipe_hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  hz_entry_t d,
  output hz_entry_t q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: scoreboard-driven bypass/stall/squash control; PIPE_HAZARD_BYPASS_EN enables bypassing.
module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter int N_STAGES   = 3,
  parameter int LOAD_STAGE = 2,
  localparam int SEL_W     = $clog2(N_STAGES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                val_D,
  input  logic                rs1_en_D,
  input  logic                rs2_en_D,
  input  logic [4:0]          rs1_D,
  input  logic [4:0]          rs2_D,
  input  logic                wen_D,
  input  logic [4:0]          waddr_D,
  input  logic                is_load_D,
  input  logic                is_branch_D,
  input  logic                is_jump_D,
  input  logic                br_taken_X,
  input  logic                mem_wait,
  output logic                stall_F,
  output logic                stall_D,
  output logic                squash_F,
  output logic                squash_D,
  output logic [SEL_W-1:0]    op1_byp_sel_D,
  output logic [SEL_W-1:0]    op2_byp_sel_D,
  output logic [N_STAGES-1:0] val_S,
  output logic                rf_wen_W,
  output logic [4:0]          rf_waddr_W
);
`ifdef PIPE_HAZARD_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif
  hz_entry_t ent [1:N_STAGES];
  hz_entry_t d_ent;
  logic lu1, lu2;
  // Descending scan so the youngest (smallest k) match is the one left standing.
  always_comb begin
    op1_byp_sel_D = SEL_W'(BYP_RF);
    op2_byp_sel_D = SEL_W'(BYP_RF);
    lu1 = 1'b0;
    lu2 = 1'b0;
    for (int k = N_STAGES; k >= 1; k--) begin
      if (val_D && hz_match(ent[k], rs1_en_D, rs1_D)) begin
        lu1 = !BYP_EN || (ent[k].is_load && k < LOAD_STAGE);
        op1_byp_sel_D = lu1 ? SEL_W'(BYP_RF) : SEL_W'(k);
      end
      if (val_D && hz_match(ent[k], rs2_en_D, rs2_D)) begin
        lu2 = !BYP_EN || (ent[k].is_load && k < LOAD_STAGE);
        op2_byp_sel_D = lu2 ? SEL_W'(BYP_RF) : SEL_W'(k);
      end
    end
  end
  assign squash_D = ~mem_wait & ent[1].val & ent[1].is_branch & br_taken_X;
  assign stall_D  = ~squash_D & ((val_D & (lu1 | lu2)) | mem_wait);
  assign stall_F  = stall_D;
  assign squash_F = squash_D | (~mem_wait & val_D & is_jump_D & ~stall_D);
  assign d_ent = '{val: val_D & ~stall_D & ~squash_D, wen: wen_D, waddr: waddr_D,
                   is_load: is_load_D, is_branch: is_branch_D};
  for (genvar i = 1; i <= N_STAGES; i++) begin : g_stage
    if (i == 1) begin : g_head
      hazard_stage_reg u_reg (.clk(clk), .rst(rst), .en(~mem_wait), .d(d_ent), .q(ent[i]));
    end else begin : g_tail
      hazard_stage_reg u_reg (.clk(clk), .rst(rst), .en(~mem_wait), .d(ent[i-1]), .q(ent[i]));
    end
  end
  always_comb begin
    val_S = '0;
    for (int k = 1; k <= N_STAGES; k++) val_S[k-1] = ent[k].val;
  end
  // Gated by rst so a W-stage entry cannot write during the reset cycle.
  assign rf_wen_W   = rst & ent[N_STAGES].val & ent[N_STAGES].wen & ~mem_wait;
  assign rf_waddr_W = rf_wen_W ? ent[N_STAGES].waddr : REG_X0;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed test-plan scenarios plus random traffic checked against a scoreboard model.
module tb_pipe_hazard_unit;
  import pipe_hazard_pkg::*;
  localparam int N  = 3;
  localparam int LS = 2;
  localparam int SW = $clog2(N + 1);
`ifdef PIPE_HAZARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst, val_D, rs1_en_D, rs2_en_D, wen_D, is_load_D, is_branch_D, is_jump_D;
  logic br_taken_X, mem_wait;
  logic [4:0] rs1_D, rs2_D, waddr_D, rf_waddr_W;
  logic stall_F, stall_D, squash_F, squash_D, rf_wen_W;
  logic [SW-1:0] op1_byp_sel_D, op2_byp_sel_D;
  logic [N-1:0] val_S;
  int tests = 0, fails = 0;
  bit chk_on = 1'b0;

  pipe_hazard_unit #(.N_STAGES(N), .LOAD_STAGE(LS)) dut (
    .clk(clk), .rst(rst), .val_D(val_D), .rs1_en_D(rs1_en_D), .rs2_en_D(rs2_en_D),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .wen_D(wen_D), .waddr_D(waddr_D), .is_load_D(is_load_D),
    .is_branch_D(is_branch_D), .is_jump_D(is_jump_D), .br_taken_X(br_taken_X),
    .mem_wait(mem_wait), .stall_F(stall_F), .stall_D(stall_D), .squash_F(squash_F),
    .squash_D(squash_D), .op1_byp_sel_D(op1_byp_sel_D), .op2_byp_sel_D(op2_byp_sel_D),
    .val_S(val_S), .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W));

  always #5 clk = ~clk;

  hz_entry_t m [1:N];
  int k1, k2;
  logic lu1, lu2, e_stall, e_sqd, e_sqf, e_wen;
  logic [4:0] e_waddr;
  logic [SW-1:0] e_s1, e_s2;
  logic [N-1:0] e_vs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task model_eval();
    k1 = 0;
    k2 = 0;
    for (int k = N; k >= 1; k--) begin
      if (val_D && rs1_en_D && m[k].val && m[k].wen && m[k].waddr == rs1_D && rs1_D != 0) k1 = k;
      if (val_D && rs2_en_D && m[k].val && m[k].wen && m[k].waddr == rs2_D && rs2_D != 0) k2 = k;
    end
    lu1 = (k1 != 0) && (!BYP || (m[k1].is_load && k1 < LS));
    lu2 = (k2 != 0) && (!BYP || (m[k2].is_load && k2 < LS));
    e_s1 = (k1 != 0 && !lu1) ? SW'(k1) : '0;
    e_s2 = (k2 != 0 && !lu2) ? SW'(k2) : '0;
    e_sqd = !mem_wait && m[1].val && m[1].is_branch && br_taken_X;
    e_stall = !e_sqd && ((val_D && (lu1 || lu2)) || mem_wait);
    e_sqf = e_sqd || (!mem_wait && val_D && is_jump_D && !e_stall);
    e_wen = rst && m[N].val && m[N].wen && !mem_wait;
    e_waddr = e_wen ? m[N].waddr : 5'd0;
    for (int k = 1; k <= N; k++) e_vs[k-1] = m[k].val;
  endtask

  initial forever begin
    @(posedge clk);
    model_eval();
    if (!rst) begin
      for (int k = 1; k <= N; k++) m[k] = '0;
    end else if (!mem_wait) begin
      for (int k = N; k > 1; k--) m[k] = m[k-1];
      m[1] = '{val: val_D && !e_stall && !e_sqd, wen: wen_D, waddr: waddr_D,
               is_load: is_load_D, is_branch: is_branch_D};
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      model_eval();
      chk("stall_D", stall_D, e_stall);
      chk("stall_F", stall_F, e_stall);
      chk("squash_D", squash_D, e_sqd);
      chk("squash_F", squash_F, e_sqf);
      chk("op1_sel", op1_byp_sel_D, e_s1);
      chk("op2_sel", op2_byp_sel_D, e_s2);
      chk("val_S", val_S, e_vs);
      chk("rf_wen_W", rf_wen_W, e_wen);
      chk("rf_waddr_W", rf_waddr_W, e_waddr);
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic settle(); #3; endtask
  task automatic idle();
    {val_D, rs1_en_D, rs2_en_D, wen_D, is_load_D, is_branch_D, is_jump_D} = '0;
    rs1_D = 0; rs2_D = 0; waddr_D = 0;
  endtask
  task automatic op(input logic [4:0] rd, input logic e1, input logic [4:0] r1,
                    input logic e2, input logic [4:0] r2);
    idle();
    val_D = 1; wen_D = 1; waddr_D = rd; rs1_en_D = e1; rs1_D = r1; rs2_en_D = e2; rs2_D = r2;
  endtask
  task automatic flush(); idle(); mem_wait = 0; br_taken_X = 0; repeat (N) tick(); endtask
  task automatic expect_stalls(input int n);
    for (int i = 0; i < n; i++) begin
      settle(); chk("stall_run", stall_D, 1'b1); tick();
    end
    settle(); chk("stall_end", stall_D, 1'b0); chk("bubble", val_S[0], 1'b0);
  endtask

  initial begin
    rst = 0; br_taken_X = 0; mem_wait = 0; idle();
    tick(); tick();
    chk_on = 1; rst = 1;
    settle();
    chk("rst_val_S", val_S, '0); chk("rst_stall", stall_D, 0); chk("rst_wen", rf_wen_W, 0);
    tick();
    // dependent ALU ops
    op(1, 0, 0, 0, 0); settle(); chk("A_nostall", stall_D, 0); tick();
    op(3, 1, 1, 1, 0);
    if (BYP) begin
      settle(); chk("A_sel1", op1_byp_sel_D, 1); chk("A_nostall2", stall_D, 0); tick();
      op(4, 1, 1, 1, 1); settle(); chk("A_sel1b", op1_byp_sel_D, 2); chk("A_sel2b", op2_byp_sel_D, 2);
    end else begin
      expect_stalls(N); chk("A_sel_rf", op1_byp_sel_D, 0);
    end
    tick(); flush();
    // load-use
    op(2, 0, 0, 0, 0); is_load_D = 1; tick();
    op(3, 1, 2, 1, 2);
    if (BYP) begin
      expect_stalls(LS - 1); chk("L_sel1", op1_byp_sel_D, LS); chk("L_sel2", op2_byp_sel_D, LS);
    end else expect_stalls(N);
    tick(); flush();
    // taken branch
    idle(); val_D = 1; is_branch_D = 1; tick();
    op(4, 0, 0, 0, 0); br_taken_X = 1; settle();
    chk("B_sqd", squash_D, 1); chk("B_sqf", squash_F, 1); chk("B_stall", stall_D, 0);
    tick(); br_taken_X = 0; idle(); settle(); chk("B_bubble", val_S[0], 0);
    tick(); flush();
    // x0 writers everywhere, then JAL
    op(0, 1, 0, 0, 0); repeat (N) tick();
    settle(); chk("J_nostall", stall_D, 0); chk("J_sel", op1_byp_sel_D, 0);
    tick(); op(0, 0, 0, 0, 0); is_jump_D = 1; settle();
    chk("J_sqf", squash_F, 1); chk("J_sqd", squash_D, 0); chk("J_stall", stall_D, 0);
    tick(); idle(); settle(); chk("J_sqf_off", squash_F, 0);
    tick(); flush();
    // mem_wait freeze with producer in W
    op(5, 0, 0, 0, 0); tick(); idle(); tick(); tick();
    mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      settle(); chk("M_wen", rf_wen_W, 0); chk("M_valS", val_S, 3'b100); chk("M_stall", stall_D, 1); tick();
    end
    mem_wait = 0; settle(); chk("M_wen_after", rf_wen_W, 1); chk("M_waddr_after", rf_waddr_W, 5);
    tick(); flush();
    // reset with a full pipe
    op(6, 0, 0, 0, 0); repeat (N) tick();
    settle(); chk("R_full", val_S, {N{1'b1}});
    tick(); rst = 0; idle(); settle(); chk("R_nowrite", rf_wen_W, 0);
    tick(); rst = 1; settle();
    chk("R_valS", val_S, '0); chk("R_wen", rf_wen_W, 0); chk("R_waddr", rf_waddr_W, 0);
    chk("R_sqf", squash_F, 0); chk("R_sel", op1_byp_sel_D, 0);
    tick();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      val_D = $urandom_range(0, 3) != 0;
      rs1_en_D = $urandom_range(0, 1); rs2_en_D = $urandom_range(0, 1);
      rs1_D = 5'($urandom_range(0, 3)); rs2_D = 5'($urandom_range(0, 3));
      wen_D = $urandom_range(0, 3) != 0; waddr_D = 5'($urandom_range(0, 3));
      is_load_D = $urandom_range(0, 3) == 0; is_branch_D = $urandom_range(0, 4) == 0;
      is_jump_D = $urandom_range(0, 9) == 0; br_taken_X = $urandom_range(0, 2) == 0;
      mem_wait = $urandom_range(0, 6) == 0; rst = $urandom_range(0, 49) != 0;
      tick();
    end
    rst = 1; mem_wait = 0; idle(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
